// File: rtl/stream_demux_1to8.sv
// stream_demux_1to8
//
// Routes one valid/ready input stream to one of eight output streams. A packet
// is locked to the channel chosen on its first beat until its last beat is
// accepted. Each output channel owns a one-entry register slot, so the block is
// also a pipeline stage with one cycle of latency from input accept to o_Valid.
//
// Ports:
//   i_Clock    clock, rising edge
//   i_Reset    synchronous reset, active-high
//   i_Select   destination channel, sampled on the first beat of a packet
//   i_Data     input beat data
//   i_Last     input beat is the last of its packet
//   i_Valid    input beat valid
//   o_Ready    input beat accepted when i_Valid && o_Ready
//   o_Data     per-channel slot data, packed [7:0][WIDTH-1:0]
//   o_Last     per-channel slot last flag
//   o_Valid    per-channel slot valid
//   i_Ready    per-channel downstream ready
//   o_Busy     a multi-beat packet is in progress
//   o_Channel  channel latched for the current or most recent packet

module stream_demux_1to8 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic [2:0]            i_Select,
  input  logic [WIDTH-1:0]      i_Data,
  input  logic                  i_Last,
  input  logic                  i_Valid,
  output logic                  o_Ready,
  output logic [7:0][WIDTH-1:0] o_Data,
  output logic [7:0]            o_Last,
  output logic [7:0]            o_Valid,
  input  logic [7:0]            i_Ready,
  output logic                  o_Busy,
  output logic [2:0]            o_Channel
);

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e                  state_q;
  logic [2:0]              channel_q;
  logic [7:0][WIDTH-1:0]   data_q;
  logic [7:0]              last_q;
  logic [7:0]              valid_q;

  logic [2:0]              ch;
  logic                    ready;
  logic                    accept;

  // While idle, routing follows i_Select live so an unaccepted beat can be
  // retargeted; once a packet is open the latched channel wins.
  always_comb begin
    ch = i_Select;
    if (state_q == StLocked) begin
      ch = channel_q;
    end
  end

  // Slot ch can take a beat if it is empty or is being drained this cycle.
  always_comb begin
    ready  = !valid_q[ch] || i_Ready[ch];
    accept = i_Valid && ready;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      channel_q <= 3'd0;
      data_q    <= '0;
      last_q    <= '0;
      valid_q   <= '0;
    end else begin
      // Per-channel slots: a load takes priority over a drain, which keeps the
      // slot valid with the new beat and sustains one beat per cycle.
      for (int k = 0; k < 8; k++) begin
        if (accept && (ch == 3'(k))) begin
          data_q[k]  <= i_Data;
          last_q[k]  <= i_Last;
          valid_q[k] <= 1'b1;
        end else if (valid_q[k] && i_Ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (accept) begin
            channel_q <= i_Select;
            if (!i_Last) begin
              state_q <= StLocked;
            end
          end
        end
        StLocked: begin
          if (accept && i_Last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_Ready   = ready;
  assign o_Data    = data_q;
  assign o_Last    = last_q;
  assign o_Valid   = valid_q;
  assign o_Busy    = (state_q == StLocked);
  assign o_Channel = channel_q;

endmodule

// File: tb/tb_stream_demux_1to8.sv
// Bench for stream_demux_1to8: directed scenarios followed by random traffic,
// all checked against a per-channel queue model of accepted-but-undelivered
// beats plus packet routing bookkeeping.

module tb_stream_demux_1to8;

  localparam int W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         sel;
  logic [W-1:0]       din;
  logic               last;
  logic               valid;
  logic               rdy;
  logic [7:0][W-1:0]  odata;
  logic [7:0]         olast;
  logic [7:0]         ovalid;
  logic [7:0]         iready;
  logic               busy;
  logic [2:0]         chan;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats accepted per channel not yet taken downstream,
  // last beat ever loaded per channel, and the open-packet routing state.
  logic [W:0]   mq [8][$];
  logic [W-1:0] hold_data [8];
  logic         hold_last [8];
  logic         m_open;
  logic [2:0]   m_ch;

  stream_demux_1to8 #(.WIDTH(W)) dut (
    .i_Clock   (clk),
    .i_Reset   (rst),
    .i_Select  (sel),
    .i_Data    (din),
    .i_Last    (last),
    .i_Valid   (valid),
    .o_Ready   (rdy),
    .o_Data    (odata),
    .o_Last    (olast),
    .o_Valid   (ovalid),
    .i_Ready   (iready),
    .o_Busy    (busy),
    .o_Channel (chan)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      mq[k].delete();
      hold_data[k] = '0;
      hold_last[k] = 1'b0;
    end
    m_open = 1'b0;
    m_ch   = 3'd0;
  endtask

  // Drive one cycle of inputs, check every output against the model, then
  // advance the model by what the coming rising edge will do.
  task automatic step(input logic [2:0] s, input logic [W-1:0] d, input logic l,
                      input logic v, input logic [7:0] r);
    logic [2:0] ech;
    logic       erdy;
    logic [W:0] front;
    @(negedge clk);
    sel = s; din = d; last = l; valid = v; iready = r;
    #1;
    ech  = m_open ? m_ch : s;
    erdy = (mq[ech].size() == 0) || r[ech];
    check_eq("ready", 64'(rdy), 64'(erdy));
    check_eq("busy", 64'(busy), 64'(m_open));
    check_eq("channel", 64'(chan), 64'(m_ch));
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("valid%0d", k), 64'(ovalid[k]), 64'(mq[k].size() != 0));
      if (mq[k].size() != 0) begin
        front = mq[k][0];
        check_eq($sformatf("data%0d", k), 64'(odata[k]), 64'(front[W-1:0]));
        check_eq($sformatf("last%0d", k), 64'(olast[k]), 64'(front[W]));
      end else begin
        check_eq($sformatf("hold_data%0d", k), 64'(odata[k]), 64'(hold_data[k]));
        check_eq($sformatf("hold_last%0d", k), 64'(olast[k]), 64'(hold_last[k]));
      end
    end
    for (int k = 0; k < 8; k++) begin
      if ((mq[k].size() != 0) && r[k]) begin
        void'(mq[k].pop_front());
      end
    end
    if (v && erdy) begin
      mq[ech].push_back({l, d});
      hold_data[ech] = d;
      hold_last[ech] = l;
      m_ch   = ech;
      m_open = !l;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'($urandom);
    iready = 8'($urandom);
    @(posedge clk);
    clear_model();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = '0; din = '0; last = 1'b0; valid = 1'b0; iready = 8'hFF;
    clear_model();
    repeat (2) @(posedge clk);
    do_reset();

    // Idle after reset.
    step(3'd0, '0, 1'b0, 1'b0, 8'hFF);
    check_eq("t1_ready_direct", 64'(rdy), 64'd1);

    // Single-beat packet to channel 5.
    step(3'd5, 32'hA5A5_0001, 1'b1, 1'b1, 8'hFF);
    step(3'd0, '0, 1'b0, 1'b0, 8'h00);
    check_eq("t2_valid_direct", 64'(ovalid), 64'h20);
    check_eq("t2_data_direct", 64'(odata[5]), 64'hA5A5_0001);
    step(3'd0, '0, 1'b0, 1'b0, 8'hFF);

    // Four-beat packet to channel 2 with select moved after beat 0.
    step(3'd2, 32'h2000_0000, 1'b0, 1'b1, 8'hFF);
    step(3'd6, 32'h2000_0001, 1'b0, 1'b1, 8'hFF);
    step(3'd6, 32'h2000_0002, 1'b0, 1'b1, 8'hFF);
    step(3'd6, 32'h2000_0003, 1'b1, 1'b1, 8'hFF);
    step(3'd6, '0, 1'b0, 1'b0, 8'hFF);
    step(3'd6, '0, 1'b0, 1'b0, 8'hFF);

    // Backpressure on channel 3, then release.
    step(3'd3, 32'h3000_0000, 1'b1, 1'b1, 8'hF7);
    step(3'd3, 32'h3000_0001, 1'b1, 1'b1, 8'hF7);
    step(3'd3, 32'h3000_0001, 1'b1, 1'b1, 8'hF7);
    step(3'd3, 32'h3000_0001, 1'b1, 1'b1, 8'hFF);
    step(3'd3, '0, 1'b0, 1'b0, 8'hFF);
    step(3'd3, '0, 1'b0, 1'b0, 8'hFF);

    // Channel 1 stalled while channel 4 flows.
    step(3'd1, 32'h1111_1111, 1'b1, 1'b1, 8'hFD);
    step(3'd4, 32'h4444_4444, 1'b1, 1'b1, 8'hFD);
    step(3'd4, '0, 1'b0, 1'b0, 8'hFD);
    step(3'd4, '0, 1'b0, 1'b0, 8'hFF);

    // Reset while locked with slots 0 and 7 full.
    step(3'd0, 32'h0000_00AA, 1'b1, 1'b1, 8'h00);
    step(3'd7, 32'h7777_0000, 1'b0, 1'b1, 8'h00);
    step(3'd7, '0, 1'b0, 1'b0, 8'h00);
    do_reset();
    step(3'd7, 32'h7777_0001, 1'b1, 1'b1, 8'hFF);
    step(3'd7, '0, 1'b0, 1'b0, 8'hFF);
    step(3'd7, '0, 1'b0, 1'b0, 8'hFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step(3'($urandom), 32'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 3) != 0), 8'($urandom) | 8'($urandom));
      end
    end
    step(3'd0, '0, 1'b0, 1'b0, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
